// File: rtl/bpu_gshare_if.sv
// Predict/update bundle for the gshare branch predictor.
// The modports are "master" (fetch/EX side) and "slave" (predictor).
interface bpu_gshare_if #(
  parameter int IDX_W = 6
);
  // Predict side is purely combinational: no valid/ready.
  // Update side: upd_valid_i is a single-cycle strobe with no ready, because the
  // predictor accepts every update. All upd_* fields are qualified by upd_valid_i
  // and are ignored when it is low.
  logic [31:0]      inst_i;
  logic [31:0]      inst_addr_i;
  logic             bp_result_o;
  logic [31:0]      bp_jump_addr_o;
  logic [IDX_W-1:0] bp_idx_o;

  logic             upd_valid_i;
  logic             upd_is_branch_i;
  logic             upd_is_jalr_i;
  logic [IDX_W-1:0] upd_idx_i;
  logic [31:0]      upd_pc_i;
  logic             upd_taken_i;
  logic [31:0]      upd_target_i;
  logic             upd_mispredict_i;
  logic [31:0]      mispred_cnt_o;

  modport master (
    output inst_i, inst_addr_i,
    output upd_valid_i, upd_is_branch_i, upd_is_jalr_i, upd_idx_i,
    output upd_pc_i, upd_taken_i, upd_target_i, upd_mispredict_i,
    input  bp_result_o, bp_jump_addr_o, bp_idx_o, mispred_cnt_o
  );

  modport slave (
    input  inst_i, inst_addr_i,
    input  upd_valid_i, upd_is_branch_i, upd_is_jalr_i, upd_idx_i,
    input  upd_pc_i, upd_taken_i, upd_target_i, upd_mispredict_i,
    output bp_result_o, bp_jump_addr_o, bp_idx_o, mispred_cnt_o
  );
endinterface

// File: rtl/bpu_gshare.sv
// Gshare predictor: 2-bit counters indexed by PC ^ global history, combinational predict,
// registered non-speculative update. Define BPU_BTB_EN to add a direct-mapped JALR target buffer.
module bpu_gshare #(
  parameter int BHT_DEPTH = 64,
  parameter int GHR_W     = 6,
  parameter int BTB_DEPTH = 16
) (
  input logic         clk,
  input logic         rst,
  bpu_gshare_if.slave bus
);
  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [1:0]       bht [BHT_DEPTH];
  logic [GHR_W-1:0] ghr;
  logic [GHR_W-1:0] ghr_next;
  logic [IDX_W-1:0] pred_idx;
  logic [31:0]      j_imm;
  logic [31:0]      b_imm;
  logic             jalr_hit;
  logic [31:0]      jalr_target;
  logic [31:0]      mispred_cnt;
  logic             upd_branch;
  logic [1:0]       upd_ctr;

  // ---------------------------------------------------------------- predict
  assign pred_idx = bus.inst_addr_i[IDX_W+1:2] ^ IDX_W'(ghr);

  assign j_imm = {{11{bus.inst_i[31]}}, bus.inst_i[31], bus.inst_i[19:12],
                  bus.inst_i[20], bus.inst_i[30:21], 1'b0};
  assign b_imm = {{19{bus.inst_i[31]}}, bus.inst_i[31], bus.inst_i[7],
                  bus.inst_i[30:25], bus.inst_i[11:8], 1'b0};

  always_comb begin
    bus.bp_result_o    = 1'b0;
    bus.bp_jump_addr_o = 32'h0;
    case (bus.inst_i[6:0])
      OP_JAL: begin
        bus.bp_result_o    = 1'b1;
        bus.bp_jump_addr_o = bus.inst_addr_i + j_imm;
      end
      OP_BRANCH: begin
        if (bht[pred_idx][1]) begin
          bus.bp_result_o    = 1'b1;
          bus.bp_jump_addr_o = bus.inst_addr_i + b_imm;
        end
      end
      OP_JALR: begin
        if (jalr_hit) begin
          bus.bp_result_o    = 1'b1;
          bus.bp_jump_addr_o = jalr_target;
        end
      end
      default: ;
    endcase
  end

  assign bus.bp_idx_o = pred_idx;

  // ---------------------------------------------------------------- BHT / GHR update
  assign upd_branch = bus.upd_valid_i && bus.upd_is_branch_i;
  assign upd_ctr    = bht[bus.upd_idx_i];
  // Truncating cast drops the oldest bit; also covers GHR_W == 1.
  assign ghr_next   = GHR_W'({ghr, bus.upd_taken_i});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= 2'b01;
      end
      ghr <= '0;
    end else if (upd_branch) begin
      if (bus.upd_taken_i) begin
        if (upd_ctr != 2'b11) bht[bus.upd_idx_i] <= upd_ctr + 2'd1;
      end else begin
        if (upd_ctr != 2'b00) bht[bus.upd_idx_i] <= upd_ctr - 2'd1;
      end
      ghr <= ghr_next;
    end
  end

  // ---------------------------------------------------------------- misprediction counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mispred_cnt <= 32'h0;
    end else if (bus.upd_valid_i && bus.upd_mispredict_i && (mispred_cnt != 32'hFFFF_FFFF)) begin
      mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

  assign bus.mispred_cnt_o = mispred_cnt;

  // ---------------------------------------------------------------- JALR target buffer
`ifdef BPU_BTB_EN
  localparam int BTB_IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W     = 30 - BTB_IDX_W;

  logic             btb_valid  [BTB_DEPTH];
  logic [TAG_W-1:0] btb_tag    [BTB_DEPTH];
  logic [31:0]      btb_target [BTB_DEPTH];
  logic [BTB_IDX_W-1:0] rd_set;
  logic [BTB_IDX_W-1:0] wr_set;
  logic                 upd_jalr;
  logic                 unused_addr_lo;

  assign rd_set   = bus.inst_addr_i[BTB_IDX_W+1:2];
  assign wr_set   = bus.upd_pc_i[BTB_IDX_W+1:2];
  assign upd_jalr = bus.upd_valid_i && bus.upd_is_jalr_i;

  assign jalr_hit    = btb_valid[rd_set] && (btb_tag[rd_set] == bus.inst_addr_i[31:BTB_IDX_W+2]);
  assign jalr_target = btb_target[rd_set];

  // Only the valid bits need reset; tag/target are don't-care while invalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        btb_valid[i] <= 1'b0;
      end
    end else if (upd_jalr) begin
      btb_valid[wr_set] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (upd_jalr) begin
      btb_tag[wr_set]    <= bus.upd_pc_i[31:BTB_IDX_W+2];
      btb_target[wr_set] <= bus.upd_target_i;
    end
  end

  assign unused_addr_lo = ^{bus.inst_addr_i[1:0], bus.upd_pc_i[1:0]};
`else
  logic unused_btb_inputs;

  assign jalr_hit    = 1'b0;
  assign jalr_target = 32'h0;

  assign unused_btb_inputs = ^{bus.upd_is_jalr_i, bus.upd_pc_i, bus.upd_target_i,
                               bus.inst_addr_i[31:IDX_W+2], bus.inst_addr_i[1:0],
                               32'(BTB_DEPTH)};
`endif

endmodule

// File: tb/tb_bpu_gshare.sv
// Directed bench for bpu_gshare: a table of predict vectors on a fresh table,
// then hand-written update sequences for counters, history, same-cycle hazards, reset and JALR.
module tb_bpu_gshare;
  localparam int IDX_W = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bpu_gshare_if #(.IDX_W(IDX_W)) bus ();

  bpu_gshare #(
    .BHT_DEPTH(64),
    .GHR_W    (6),
    .BTB_DEPTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] pc;
  } vec_t;

  vec_t        vecs[$];
  logic [38:0] exp_q[$];   // {taken, target, idx}
  int          n_vec = 0;
  int          n_err = 0;

  localparam logic [31:0] JALR_X1 = 32'h000080E7;
  localparam logic [31:0] ADDI_X1 = 32'h00100093;
  localparam logic [31:0] LUI_X1  = 32'h000010B7;

  function automatic logic [31:0] enc_jal(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_br(input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic add_vec(input string name, input logic [31:0] inst, input logic [31:0] pc,
                         input logic taken, input logic [31:0] tgt, input logic [IDX_W-1:0] idx);
    vec_t v;
    v.name = name;
    v.inst = inst;
    v.pc   = pc;
    vecs.push_back(v);
    exp_q.push_back({taken, tgt, idx});
  endtask

  task automatic check_pred(input string name, input logic [31:0] inst, input logic [31:0] pc,
                            input logic [38:0] exp);
    logic [38:0] act;
    bus.inst_i      = inst;
    bus.inst_addr_i = pc;
    #1;
    act = {bus.bp_result_o, bus.bp_jump_addr_o, bus.bp_idx_o};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got taken=%0b addr=%h idx=%h, want taken=%0b addr=%h idx=%h",
               name, act[38], act[37:6], act[5:0], exp[38], exp[37:6], exp[5:0]);
    end
  endtask

  task automatic check_cnt(input string name, input logic [31:0] exp);
    n_vec++;
    if (bus.mispred_cnt_o !== exp) begin
      n_err++;
      $display("FAIL %s: got mispred_cnt=%0d, want %0d", name, bus.mispred_cnt_o, exp);
    end
  endtask

  task automatic upd_drive(input logic br, input logic jalr, input logic [IDX_W-1:0] idx,
                           input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                           input logic misp);
    bus.upd_valid_i      = 1'b1;
    bus.upd_is_branch_i  = br;
    bus.upd_is_jalr_i    = jalr;
    bus.upd_idx_i        = idx;
    bus.upd_pc_i         = pc;
    bus.upd_taken_i      = taken;
    bus.upd_target_i     = tgt;
    bus.upd_mispredict_i = misp;
  endtask

  task automatic upd_end();
    @(posedge clk);
    #1;
    bus.upd_valid_i      = 1'b0;
    bus.upd_is_branch_i  = 1'b0;
    bus.upd_is_jalr_i    = 1'b0;
    bus.upd_idx_i        = '0;
    bus.upd_pc_i         = 32'h0;
    bus.upd_taken_i      = 1'b0;
    bus.upd_target_i     = 32'h0;
    bus.upd_mispredict_i = 1'b0;
  endtask

  task automatic branch_upd(input logic [IDX_W-1:0] idx, input logic taken);
    @(negedge clk);
    upd_drive(1'b1, 1'b0, idx, 32'h0, taken, 32'h0, 1'b0);
    upd_end();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bus.inst_i           = 32'h0;
    bus.inst_addr_i      = 32'h0;
    bus.upd_valid_i      = 1'b0;
    bus.upd_is_branch_i  = 1'b0;
    bus.upd_is_jalr_i    = 1'b0;
    bus.upd_idx_i        = '0;
    bus.upd_pc_i         = 32'h0;
    bus.upd_taken_i      = 1'b0;
    bus.upd_target_i     = 32'h0;
    bus.upd_mispredict_i = 1'b0;

    // Fresh table: counters 01, GHR 0, so idx == PC[7:2].
    add_vec("b_reset",    enc_br(13'h040),    32'h0000_0100, 1'b0, 32'h0,         6'h00);
    add_vec("jal_fwd",    enc_jal(21'h00020), 32'h0000_0200, 1'b1, 32'h0000_0220, 6'h00);
    add_vec("jal_back",   enc_jal(21'h1FFFF8), 32'h0000_1000, 1'b1, 32'h0000_0FF8, 6'h00);
    add_vec("jal_wrap",   enc_jal(21'h1FFFFC), 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 6'h00);
    add_vec("jal_maxpos", enc_jal(21'h0FFFFE), 32'h0000_0004, 1'b1, 32'h0010_0002, 6'h01);
    add_vec("b_idx",      enc_br(13'h1FFC),   32'h0000_0044, 1'b0, 32'h0,         6'h11);
    add_vec("jalr_empty", JALR_X1,            32'h0000_0300, 1'b0, 32'h0,         6'h00);
    add_vec("addi",       ADDI_X1,            32'h0000_0048, 1'b0, 32'h0,         6'h12);
    add_vec("lui_top",    LUI_X1,             32'h0000_00FC, 1'b0, 32'h0,         6'h3F);

    repeat (2) @(negedge clk);
    check_cnt("reset_cnt", 32'd0);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      check_pred(vecs[i].name, vecs[i].inst, vecs[i].pc, exp_q.pop_front());
    end

    // Counter on idx 0x05: 1 -> 2 -> 3, GHR 000011.
    branch_upd(6'h05, 1'b1);
    branch_upd(6'h05, 1'b1);
    @(negedge clk);
    check_pred("ctr_taken", enc_br(13'h040), 32'h0000_0018, {1'b1, 32'h0000_0058, 6'h05});
    // Saturate at 3, then one not-taken -> 2, GHR 001110.
    branch_upd(6'h05, 1'b1);
    branch_upd(6'h05, 1'b0);
    @(negedge clk);
    check_pred("ctr_sat_hi", enc_br(13'h040), 32'h0000_002C, {1'b1, 32'h0000_006C, 6'h05});
    // 2 -> 1 -> 0 -> 0 -> 0, then taken -> 1; GHR 000001.
    repeat (4) branch_upd(6'h05, 1'b0);
    branch_upd(6'h05, 1'b1);
    @(negedge clk);
    check_pred("ctr_sat_lo", enc_br(13'h040), 32'h0000_0010, {1'b0, 32'h0, 6'h05});

    // History: T,T,N from reset -> GHR 000110; PC 0x40 -> idx 0x16.
    apply_reset();
    branch_upd(6'h3F, 1'b1);
    branch_upd(6'h3F, 1'b1);
    branch_upd(6'h3F, 1'b0);
    @(negedge clk);
    check_pred("ghr_idx", enc_br(13'h040), 32'h0000_0040, {1'b0, 32'h0, 6'h16});

    // Same-cycle update of idx 0x16 and predict on idx 0x16.
    @(negedge clk);
    upd_drive(1'b1, 1'b0, 6'h16, 32'h0, 1'b1, 32'h0, 1'b0);
    check_pred("same_cycle_old", enc_br(13'h040), 32'h0000_0040, {1'b0, 32'h0, 6'h16});
    upd_end();
    // GHR now 001101; PC 0x6C -> 0x1B ^ 0x0D = 0x16.
    check_pred("same_cycle_new", enc_br(13'h040), 32'h0000_006C, {1'b1, 32'h0000_00AC, 6'h16});
    check_pred("ghr_shift_pc40", enc_br(13'h040), 32'h0000_0040, {1'b0, 32'h0, 6'h1D});

    // Update fields with valid low: nothing may change.
    @(negedge clk);
    upd_drive(1'b1, 1'b0, 6'h16, 32'h0, 1'b0, 32'h0, 1'b1);
    bus.upd_valid_i = 1'b0;
    upd_end();
    check_pred("valid_low_pred", enc_br(13'h040), 32'h0000_006C, {1'b1, 32'h0000_00AC, 6'h16});
    check_cnt("valid_low_cnt", 32'd0);

    // Non-branch update with mispredict: BHT/GHR unchanged, counter increments.
    @(negedge clk);
    upd_drive(1'b0, 1'b0, 6'h16, 32'h0, 1'b0, 32'h0, 1'b1);
    upd_end();
    check_pred("nonbranch_pred", enc_br(13'h040), 32'h0000_006C, {1'b1, 32'h0000_00AC, 6'h16});
    check_cnt("mispred_1", 32'd1);
    repeat (2) begin
      @(negedge clk);
      upd_drive(1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 32'h0, 1'b1);
      upd_end();
    end
    check_cnt("mispred_3", 32'd3);

    // Asynchronous reset between edges.
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_cnt("async_rst_cnt", 32'd0);
    check_pred("async_rst_bht", enc_br(13'h040), 32'h0000_0058, {1'b0, 32'h0, 6'h16});
    @(negedge clk);
    rst = 1'b1;

    // JALR resolve PC 0x300 -> 0x1000; 0x340 shares the set with a different tag.
    @(negedge clk);
    upd_drive(1'b0, 1'b1, 6'h00, 32'h0000_0300, 1'b1, 32'h0000_1000, 1'b0);
    upd_end();
    @(negedge clk);
`ifdef BPU_BTB_EN
    check_pred("jalr_hit",      JALR_X1, 32'h0000_0300, {1'b1, 32'h0000_1000, 6'h00});
    check_pred("jalr_tag_miss", JALR_X1, 32'h0000_0340, {1'b0, 32'h0,         6'h10});
`else
    check_pred("jalr_no_btb",     JALR_X1, 32'h0000_0300, {1'b0, 32'h0, 6'h00});
    check_pred("jalr_no_btb_340", JALR_X1, 32'h0000_0340, {1'b0, 32'h0, 6'h10});
`endif
    check_pred("jal_after", enc_jal(21'h00020), 32'h0000_0200, {1'b1, 32'h0000_0220, 6'h00});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
